// File: rtl/ldst_queue_if.sv
// Data-memory request bus between the load/store queue (master) and memory (slave).
interface ldst_queue_if;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_mem_address;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;

    modport master (
        output data_read, data_write, data_mem_address, data_mbe, data_mem_wdata,
        input  data_mem_resp, data_mem_rdata
    );
    modport slave (
        input  data_read, data_write, data_mem_address, data_mbe, data_mem_wdata,
        output data_mem_resp, data_mem_rdata
    );
endinterface

// File: rtl/ldst_queue.sv
// In-order load/store queue: CDB operand snoop, commit-gated stores, one memory op at a time.
// Optional LDSTQ_MISALIGN_CHK_EN: misaligned half/word ops skip memory and pulse `misalign`.
module ldst_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [31:0]               imm,
    input  logic [TAG_W-1:0]          rob_tag,
    input  logic                      base_valid,
    input  logic [TAG_W-1:0]          base_tag,
    input  logic [31:0]               base_data,
    input  logic                      src_valid,
    input  logic [TAG_W-1:0]          src_tag,
    input  logic [31:0]               src_data,
    input  logic [(2**TAG_W)-1:0]     cdb_valid,
    input  logic [32*(2**TAG_W)-1:0]  cdb_data,
    input  logic                      st_commit,
    input  logic [TAG_W-1:0]          st_commit_tag,
    input  logic                      flush,
    output logic                      ldst_q_full,
    ldst_queue_if.master              mem,
    output logic                      ld_done,
    output logic [TAG_W-1:0]          ld_tag,
    output logic [31:0]               ld_data
`ifdef LDSTQ_MISALIGN_CHK_EN
    ,
    output logic                      misalign
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic             st;
        logic [2:0]       f3;
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             bv;
        logic [TAG_W-1:0] bt;
        logic [31:0]      bd;
        logic             sv;
        logic [TAG_W-1:0] stg;
        logic [31:0]      sd;
        logic             cm;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DRAIN} state_t;

    entry_t           r_q [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head, r_tail;
    logic [PW:0]      r_count;
    state_t           r_state, w_next;

    logic             r_rd, r_wr;
    logic [31:0]      r_addr, r_wd;
    logic [3:0]       r_mbe;
    logic [1:0]       r_lane;
    logic [2:0]       r_f3;
    logic             r_ld_done, r_mis;
    logic [TAG_W-1:0] r_ld_tag;
    logic [31:0]      r_ld_data;

    logic [31:0] w_cdb [2**TAG_W];
    entry_t      w_new;
    logic        w_full, w_enq, w_deq, w_issue, w_done, w_mis_op, w_req_clr;
    logic        w_ready, w_mis;
    logic [31:0] w_ea, w_sh, w_ext;
    logic [1:0]  w_lane;
    logic [3:0]  w_mbe;

    always_comb begin
        for (int i = 0; i < 2**TAG_W; i++) w_cdb[i] = cdb_data[32*i +: 32];
    end

    assign w_full      = (r_count == (PW+1)'(DEPTH));
    assign ldst_q_full = w_full;
    assign w_enq       = load && !w_full && !flush;

    // New entry, with same-cycle CDB capture so a just-broadcast value is not missed
    always_comb begin
        w_new     = '0;
        w_new.st  = is_store;
        w_new.f3  = funct3;
        w_new.imm = imm;
        w_new.tag = rob_tag;
        w_new.bv  = base_valid;
        w_new.bt  = base_tag;
        w_new.bd  = base_data;
        if (!base_valid && cdb_valid[base_tag]) begin
            w_new.bv = 1'b1;
            w_new.bd = w_cdb[base_tag];
        end
        w_new.sv  = src_valid || !is_store;
        w_new.stg = src_tag;
        w_new.sd  = src_data;
        if (!w_new.sv && cdb_valid[src_tag]) begin
            w_new.sv = 1'b1;
            w_new.sd = w_cdb[src_tag];
        end
        w_new.cm  = is_store && st_commit && (st_commit_tag == rob_tag);
    end

    always_comb begin
        w_ea    = r_q[r_head].bd + r_q[r_head].imm;
        w_ready = r_vld[r_head] && r_q[r_head].bv &&
                  (!r_q[r_head].st || (r_q[r_head].cm && r_q[r_head].sv));
        case (r_q[r_head].f3[1:0])
            2'b00:   begin w_lane = w_ea[1:0];         w_mbe = 4'b0001 << w_ea[1:0]; end
            2'b01:   begin w_lane = {w_ea[1], 1'b0};   w_mbe = 4'b0011 << {w_ea[1], 1'b0}; end
            default: begin w_lane = 2'b00;             w_mbe = 4'b1111; end
        endcase
`ifdef LDSTQ_MISALIGN_CHK_EN
        w_mis = ((r_q[r_head].f3[1:0] == 2'b01) && w_ea[0]) ||
                ((r_q[r_head].f3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
`else
        w_mis = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_deq     = 1'b0;
        w_done    = 1'b0;
        w_mis_op  = 1'b0;
        w_req_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && w_ready) begin
                    if (w_mis) begin
                        w_mis_op = 1'b1;
                        w_deq    = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = S_MEM;
                    end
                end
            end
            S_MEM: begin
                if (mem.data_mem_resp) begin
                    w_req_clr = 1'b1;
                    w_next    = S_IDLE;
                    if (!flush) begin
                        w_deq  = 1'b1;
                        w_done = !r_q[r_head].st;
                    end
                end else if (flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem.data_mem_resp) begin
                    w_req_clr = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i]) begin
                    if (!r_q[i].bv && cdb_valid[r_q[i].bt]) begin
                        r_q[i].bv <= 1'b1;
                        r_q[i].bd <= w_cdb[r_q[i].bt];
                    end
                    if (!r_q[i].sv && cdb_valid[r_q[i].stg]) begin
                        r_q[i].sv <= 1'b1;
                        r_q[i].sd <= w_cdb[r_q[i].stg];
                    end
                    if (st_commit && r_q[i].st && (r_q[i].tag == st_commit_tag))
                        r_q[i].cm <= 1'b1;
                end
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_q[r_tail]   <= w_new;
                r_tail        <= r_tail + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Pointers realign to zero so count stays consistent with tail - head
            if (flush) begin
                r_vld   <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end
        end
    end

    always_comb begin
        w_sh = mem.data_mem_rdata >> {r_lane, 3'b000};
        case (r_f3)
            3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_ext = {24'b0, w_sh[7:0]};
            3'b101:  w_ext = {16'b0, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wd      <= '0;
            r_mbe     <= '0;
            r_lane    <= '0;
            r_f3      <= '0;
            r_ld_done <= 1'b0;
            r_mis     <= 1'b0;
            r_ld_tag  <= '0;
            r_ld_data <= '0;
        end else begin
            r_ld_done <= 1'b0;
            r_mis     <= 1'b0;
            if (w_issue) begin
                r_rd   <= !r_q[r_head].st;
                r_wr   <= r_q[r_head].st;
                r_addr <= {w_ea[31:2], 2'b00};
                r_mbe  <= w_mbe;
                r_wd   <= r_q[r_head].sd << {w_lane, 3'b000};
                r_lane <= w_lane;
                r_f3   <= r_q[r_head].f3;
            end else if (w_req_clr) begin
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end
            if (w_done) begin
                r_ld_done <= 1'b1;
                r_ld_tag  <= r_q[r_head].tag;
                r_ld_data <= w_ext;
            end
            if (w_mis_op) begin
                r_mis     <= 1'b1;
                r_ld_done <= !r_q[r_head].st;
                r_ld_tag  <= r_q[r_head].tag;
                r_ld_data <= '0;
            end
        end
    end

    assign mem.data_read        = r_rd;
    assign mem.data_write       = r_wr;
    assign mem.data_mem_address = r_addr;
    assign mem.data_mbe         = r_mbe;
    assign mem.data_mem_wdata   = r_wd;
    assign ld_done              = r_ld_done;
    assign ld_tag               = r_ld_tag;
    assign ld_data              = r_ld_data;
`ifdef LDSTQ_MISALIGN_CHK_EN
    assign misalign             = r_mis;
`endif

endmodule

// File: tb/tb_ldst_queue.sv
// Directed bench for ldst_queue: vector table for single ops, hand sequences for multi-cycle cases.
module tb_ldst_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic         clk = 1'b0;
    logic         rst, load, is_store, base_valid, src_valid, st_commit, flush;
    logic [2:0]   funct3, rob_tag, base_tag, src_tag, st_commit_tag;
    logic [31:0]  imm, base_data, src_data;
    logic [7:0]   cdb_valid;
    logic [255:0] cdb_data;
    logic         ldst_q_full, ld_done;
    logic [2:0]   ld_tag;
    logic [31:0]  ld_data;
`ifdef LDSTQ_MISALIGN_CHK_EN
    logic         misalign;
`endif

    ldst_queue_if u_if ();

    ldst_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .load(load), .is_store(is_store), .funct3(funct3),
        .imm(imm), .rob_tag(rob_tag), .base_valid(base_valid), .base_tag(base_tag),
        .base_data(base_data), .src_valid(src_valid), .src_tag(src_tag),
        .src_data(src_data), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .st_commit(st_commit), .st_commit_tag(st_commit_tag), .flush(flush),
        .ldst_q_full(ldst_q_full), .mem(u_if.master), .ld_done(ld_done),
        .ld_tag(ld_tag), .ld_data(ld_data)
`ifdef LDSTQ_MISALIGN_CHK_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base, imm, src, rdata, addr;
        logic [3:0]  mbe;
        logic [31:0] wdata, ldata;
    } vec_t;

    vec_t vt [12];
    int   nv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic enq(input logic st, input logic [2:0] f3, input logic [31:0] im,
                       input logic [2:0] tg, input logic bv, input logic [2:0] bt,
                       input logic [31:0] bd, input logic [31:0] sd);
        load = 1'b1; is_store = st; funct3 = f3; imm = im; rob_tag = tg;
        base_valid = bv; base_tag = bt; base_data = bd;
        src_valid = 1'b1; src_tag = 3'd0; src_data = sd;
        @(negedge clk);
        load = 1'b0; base_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (u_if.data_read || u_if.data_write) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, {31'b0, got}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] rd);
        u_if.data_mem_resp  = 1'b1;
        u_if.data_mem_rdata = rd;
        @(negedge clk);
        u_if.data_mem_resp  = 1'b0;
    endtask

    task automatic no_req(input string nm, input int n);
        bit seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (u_if.data_read || u_if.data_write) seen = 1'b1;
            @(negedge clk);
        end
        chk(nm, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; is_store = 1'b0; funct3 = 3'd0; imm = '0; rob_tag = '0;
        base_valid = 1'b0; base_tag = '0; base_data = '0; src_valid = 1'b0; src_tag = '0;
        src_data = '0; cdb_valid = '0; cdb_data = '0; st_commit = 1'b0; st_commit_tag = '0;
        flush = 1'b0; u_if.data_mem_resp = 1'b0; u_if.data_mem_rdata = '0;

        //             st    f3      base          imm           src           rdata         addr          mbe      wdata         ldata
        vt[0] = '{1'b0, 3'b010, 32'h0000_1000, 32'h0000_0008, 32'h0,        32'h600D_600D, 32'h0000_1008, 4'b1111, 32'h0,        32'h600D_600D};
        vt[1] = '{1'b0, 3'b000, 32'h0000_3000, 32'h0000_0001, 32'h0,        32'h1122_8344, 32'h0000_3000, 4'b0010, 32'h0,        32'hFFFF_FF83};
        vt[2] = '{1'b0, 3'b100, 32'h0000_3000, 32'h0000_0003, 32'h0,        32'h9A00_0000, 32'h0000_3000, 4'b1000, 32'h0,        32'h0000_009A};
        vt[3] = '{1'b0, 3'b001, 32'h0000_4000, 32'h0000_0002, 32'h0,        32'hBEEF_1234, 32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF_BEEF};
        vt[4] = '{1'b0, 3'b101, 32'h0000_4000, 32'h0000_0000, 32'h0,        32'hBEEF_8234, 32'h0000_4000, 4'b0011, 32'h0,        32'h0000_8234};
        vt[5] = '{1'b1, 3'b010, 32'h0000_5000, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        32'h0000_5004, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vt[6] = '{1'b1, 3'b001, 32'h0000_5000, 32'h0000_0002, 32'h0000_1234, 32'h0,        32'h0000_5000, 4'b1100, 32'h1234_0000, 32'h0};
        vt[7] = '{1'b1, 3'b000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0,        32'h0000_000C, 4'b1000, 32'h5500_0000, 32'h0};
        vt[8] = '{1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,        32'h0BAD_CAFE, 32'h0000_0004, 4'b1111, 32'h0,        32'h0BAD_CAFE};
        nv = 9;
`ifndef LDSTQ_MISALIGN_CHK_EN
        vt[9]  = '{1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_1000, 4'b1111, 32'h0, 32'h1234_5678};
        vt[10] = '{1'b0, 3'b001, 32'h0000_1003, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0000_1000, 4'b1100, 32'h0, 32'h0000_7FFF};
        nv = 11;
`endif

        repeat (3) @(negedge clk);
        chk("rst_read",  {31'b0, u_if.data_read},  32'd0);
        chk("rst_write", {31'b0, u_if.data_write}, 32'd0);
        chk("rst_mbe",   {28'b0, u_if.data_mbe},   32'd0);
        chk("rst_addr",  u_if.data_mem_address,    32'd0);
        chk("rst_wdata", u_if.data_mem_wdata,      32'd0);
        chk("rst_done",  {31'b0, ld_done},         32'd0);
        chk("rst_tag",   {29'b0, ld_tag},          32'd0);
        chk("rst_data",  ld_data,                  32'd0);
        chk("rst_full",  {31'b0, ldst_q_full},     32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < nv; i++) begin
            logic [2:0] tg;
            logic [31:0] a0;
            tg = 3'(i);
            enq(vt[i].st, vt[i].f3, vt[i].imm, tg, 1'b1, 3'd0, vt[i].base, vt[i].src);
            if (vt[i].st) begin
                st_commit = 1'b1; st_commit_tag = tg;
                @(negedge clk);
                st_commit = 1'b0;
            end
            wait_req($sformatf("v%0d_req", i));
            a0 = u_if.data_mem_address;
            chk($sformatf("v%0d_addr", i), a0, vt[i].addr);
            chk($sformatf("v%0d_mbe", i), {28'b0, u_if.data_mbe}, {28'b0, vt[i].mbe});
            chk($sformatf("v%0d_rd", i), {31'b0, u_if.data_read}, {31'b0, !vt[i].st});
            chk($sformatf("v%0d_wr", i), {31'b0, u_if.data_write}, {31'b0, vt[i].st});
            if (vt[i].st) chk($sformatf("v%0d_wdata", i), u_if.data_mem_wdata, vt[i].wdata);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_hold", i), {31'b0, u_if.data_read | u_if.data_write}, 32'd1);
            chk($sformatf("v%0d_hold_addr", i), u_if.data_mem_address, a0);
            respond(vt[i].rdata);
            chk($sformatf("v%0d_done", i), {31'b0, ld_done}, {31'b0, !vt[i].st});
            chk($sformatf("v%0d_req_clr", i), {31'b0, u_if.data_read | u_if.data_write}, 32'd0);
            if (!vt[i].st) begin
                chk($sformatf("v%0d_tag", i), {29'b0, ld_tag}, {29'b0, tg});
                chk($sformatf("v%0d_ldata", i), ld_data, vt[i].ldata);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'b0, ld_done}, 32'd0);
        end

        // Store waits for its own commit; a commit to another tag does nothing
        enq(1'b1, 3'b000, 32'h0, 3'd2, 1'b1, 3'd0, 32'h0000_2003, 32'h0000_00AB);
        no_req("st_nocommit", 4);
        st_commit = 1'b1; st_commit_tag = 3'd3;
        @(negedge clk);
        st_commit = 1'b0;
        no_req("st_wrongtag", 4);
        st_commit = 1'b1; st_commit_tag = 3'd2;
        @(negedge clk);
        st_commit = 1'b0;
        wait_req("st_req");
        chk("st_write", {31'b0, u_if.data_write}, 32'd1);
        chk("st_addr",  u_if.data_mem_address, 32'h0000_2000);
        chk("st_mbe",   {28'b0, u_if.data_mbe}, 32'h8);
        chk("st_wdata", u_if.data_mem_wdata, 32'hAB00_0000);
        respond(32'h0);
        chk("st_nodone", {31'b0, ld_done}, 32'd0);

        // CDB wakeup of a waiting base, then capture on the enqueue cycle itself
        enq(1'b0, 3'b001, 32'h0, 3'd3, 1'b0, 3'd5, 32'h0, 32'h0);
        no_req("cdb_wait", 4);
        cdb_valid = 8'h20; cdb_data[5*32 +: 32] = 32'h0000_3002;
        @(negedge clk);
        cdb_valid = 8'h00;
        wait_req("cdb_req");
        chk("cdb_addr", u_if.data_mem_address, 32'h0000_3000);
        chk("cdb_mbe",  {28'b0, u_if.data_mbe}, 32'hC);
        respond(32'h8001_1234);
        chk("cdb_lh_done", {31'b0, ld_done}, 32'd1);
        chk("cdb_lh_tag",  {29'b0, ld_tag}, 32'd3);
        chk("cdb_lh_data", ld_data, 32'hFFFF_8001);
        cdb_valid = 8'h20;
        enq(1'b0, 3'b101, 32'h0, 3'd4, 1'b0, 3'd5, 32'h0, 32'h0);
        cdb_valid = 8'h00;
        wait_req("cdb2_req");
        respond(32'h8001_1234);
        chk("cdb_lhu_done", {31'b0, ld_done}, 32'd1);
        chk("cdb_lhu_data", ld_data, 32'h0000_8001);

        // Fill to DEPTH across the pointer wrap, then an ignored enqueue during a dequeue
        for (int k = 4; k < 8; k++) begin
            enq(1'b0, 3'b010, 32'h0, 3'(k), 1'b1, 3'd0, 32'(k * 256), 32'h0);
            if (k == 6) chk("full_at3", {31'b0, ldst_q_full}, 32'd0);
        end
        chk("full_at4", {31'b0, ldst_q_full}, 32'd1);
        wait_req("full_req4");
        load = 1'b1; is_store = 1'b0; funct3 = 3'b010; rob_tag = 3'd1;
        base_valid = 1'b1; base_data = 32'h9000; imm = 32'h0;
        u_if.data_mem_resp = 1'b1; u_if.data_mem_rdata = 32'h0000_0004;
        @(negedge clk);
        load = 1'b0; base_valid = 1'b0; u_if.data_mem_resp = 1'b0;
        chk("full_tag4", {29'b0, ld_tag}, 32'd4);
        chk("full_done4", {31'b0, ld_done}, 32'd1);
        chk("full_after_deq", {31'b0, ldst_q_full}, 32'd0);
        for (int k = 5; k < 8; k++) begin
            wait_req($sformatf("full_req%0d", k));
            chk($sformatf("full_addr%0d", k), u_if.data_mem_address, 32'(k * 256));
            respond(32'(k));
            chk($sformatf("full_tag%0d", k), {29'b0, ld_tag}, 32'(k));
            chk($sformatf("full_data%0d", k), ld_data, 32'(k));
        end
        no_req("full_5th_ignored", 10);

        // Flush while in MEM with three entries; enqueue on the flush cycle is dropped
        for (int k = 1; k < 4; k++) enq(1'b0, 3'b010, 32'h0, 3'(k), 1'b1, 3'd0, 32'h100, 32'h0);
        wait_req("fl_req");
        flush = 1'b1;
        load = 1'b1; is_store = 1'b0; funct3 = 3'b010; rob_tag = 3'd4;
        base_valid = 1'b1; base_data = 32'h200;
        @(negedge clk);
        flush = 1'b0; load = 1'b0; base_valid = 1'b0;
        chk("fl_held", {31'b0, u_if.data_read}, 32'd1);
        chk("fl_full", {31'b0, ldst_q_full}, 32'd0);
        repeat (2) @(negedge clk);
        chk("fl_held2", {31'b0, u_if.data_read}, 32'd1);
        respond(32'h0000_DEAD);
        chk("fl_nodone", {31'b0, ld_done}, 32'd0);
        chk("fl_req_clr", {31'b0, u_if.data_read}, 32'd0);
        no_req("fl_empty", 10);
        for (int k = 0; k < 4; k++) begin
            enq(1'b0, 3'b010, 32'h0, 3'(k), 1'b1, 3'd0, 32'h300, 32'h0);
            if (k == 2) chk("fl_cnt3_full", {31'b0, ldst_q_full}, 32'd0);
        end
        chk("fl_cnt4_full", {31'b0, ldst_q_full}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        respond(32'h0);
        chk("fl2_nodone", {31'b0, ld_done}, 32'd0);
        no_req("fl2_empty", 8);

`ifdef LDSTQ_MISALIGN_CHK_EN
        begin
            bit seen_rd = 1'b0;
            bit got = 1'b0;
            enq(1'b0, 3'b010, 32'h0, 3'd6, 1'b1, 3'd0, 32'h0000_1002, 32'h0);
            for (int k = 0; k < 10; k++) begin
                if (u_if.data_read) seen_rd = 1'b1;
                if (misalign) begin got = 1'b1; break; end
                @(negedge clk);
            end
            chk("mis_pulse", {31'b0, got}, 32'd1);
            chk("mis_noread", {31'b0, seen_rd}, 32'd0);
            chk("mis_done", {31'b0, ld_done}, 32'd1);
            chk("mis_tag", {29'b0, ld_tag}, 32'd6);
            chk("mis_data", ld_data, 32'd0);
            no_req("mis_noreq", 5);
        end
`endif

        // Reset in the middle of a request drops it and empties the queue
        enq(1'b0, 3'b010, 32'h0, 3'd5, 1'b1, 3'd0, 32'h400, 32'h0);
        enq(1'b0, 3'b010, 32'h0, 3'd6, 1'b1, 3'd0, 32'h500, 32'h0);
        wait_req("rst_mid_req");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_drop", {31'b0, u_if.data_read}, 32'd0);
        chk("rst_mid_full", {31'b0, ldst_q_full}, 32'd0);
        no_req("rst_mid_empty", 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ldst_queue.md
Name: ldst_queue

Overview:
- In-order load/store queue downstream of the instruction queue; consumes the `resldst_load` enqueue and drives `ldst_q_full` back to it.
- Holds memory ops with renamed operands and snoops the CDB for missing base/store-data values.
- Issues one data-memory request at a time from the head, in program order:
  - stores only after the ROB commits them;
  - loads as soon as their address is ready.
- Load results are returned to the ROB/CDB side via `ld_done`.

Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2)
- TAG_W, 3, ROB tag width (ROB has 2^TAG_W = 8 entries)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load  in  1  enqueue strobe (`resldst_load`)
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- imm  in  32  sign-extended offset
- rob_tag  in  TAG_W  ROB entry of this op
- base_valid / base_tag / base_data  in  1/TAG_W/32  rs1 operand, or its producer tag
- src_valid / src_tag / src_data  in  1/TAG_W/32  store-data operand, or its producer tag
- cdb_valid  in  2^TAG_W  per-tag broadcast valid
- cdb_data  in  32*2^TAG_W  tag i at bits [32i+31:32i]
- st_commit  in  1  ROB commits store at `st_commit_tag`
- st_commit_tag  in  TAG_W
- flush  in  1  branch mispredict: drop all entries
- ldst_q_full  out  1  count == DEPTH
- data_read / data_write  out  1/1  memory request, held until resp
- data_mem_address  out  32  word-aligned (addr & ~3)
- data_mbe  out  4  byte enables
- data_mem_wdata  out  32  store data shifted to byte lane
- data_mem_resp  in  1  request complete
- data_mem_rdata  in  32  load word
- ld_done  out  1  one-cycle pulse, load result valid
- ld_tag  out  TAG_W  ROB tag of completed load
- ld_data  out  32  extended load result

Behaviour:
- **Reset (synchronous, active-high, on clk rising edge):**
  - head = tail = count = 0; all entries invalid; FSM = IDLE.
  - `data_read`, `data_write`, `ld_done`, `data_mbe` = 0; `ld_tag`, `ld_data`, `data_mem_address`, `data_mem_wdata` = 0; `ldst_q_full` = 0.
  - Reset mid-request drops the request immediately.
- **Enqueue:**
  - `load` && !full writes entry at tail; tail += 1 mod DEPTH.
  - `load` while full is ignored, even if a dequeue happens that cycle.
- **Operand capture:**
  - An invalid operand in any entry (including the one being enqueued this cycle) whose tag has `cdb_valid` set latches that CDB data and becomes valid at the next edge.
  - Loads treat the src operand as valid.
- **Store commit:**
  - `st_commit` sets the committed bit of the valid store entry whose `rob_tag` matches `st_commit_tag`.
- **FSM states:** IDLE, MEM, DRAIN.
  - IDLE → MEM when head is valid, its base is valid, and either:
    - head is a load; or
    - head is a store that is committed and has valid src.
  - On that transition, register:
    - address = base + imm (mod 2^32);
    - mbe: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111;
    - wdata = src << 8*a[1:0];
    - assert `data_read` or `data_write` from the next cycle.
  - MEM holds all request outputs stable until `data_mem_resp`. On resp:
    - deassert the request the following cycle;
    - dequeue head (head += 1, count −= 1);
    - return to IDLE.
  - For a load, the cycle after resp: `ld_done` = 1, `ld_tag` = entry tag, `ld_data` = extracted byte/half/word, sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - IDLE → MEM is earliest the cycle after resp; there are no back-to-back requests.
- **Flush:**
  - Clears all entries and count next edge; `ldst_q_full` = 0.
  - In MEM: go to DRAIN, keeping the request asserted until `data_mem_resp`, then IDLE with no `ld_done` and no dequeue.
  - Flush in DRAIN/IDLE: remains/stays.
  - Enqueue in the same cycle as flush is discarded.
- **Simultaneous enqueue and dequeue:** count unchanged.
- **Pointer wrap:** head and tail both wrap mod DEPTH.

Optional Feature:
- Macro: LDSTQ_MISALIGN_CHK_EN.
- **Defined:**
  - Adds output `misalign` (1 bit, reset 0).
  - A head op with a halfword address where a[0] = 1, or a word address where a[1:0] ≠ 0, issues no memory request.
  - It dequeues in one cycle; `misalign` pulses with `ld_tag` = its tag; for a load `ld_done` also pulses with `ld_data` = 0.
- **Undefined:**
  - No `misalign` port.
  - Low address bits are ignored for the lane: word uses mbe 1111; half uses {a[1],0}.

Test Plan:
- **Load, base ready:** enqueue LW base = 0x1000, imm = 8; resp 2 cycles later with rdata = 0x600D600D → address 0x1008, mbe 1111, `ld_done` with data 0x600D600D and correct tag.
- **Store waits for commit:** enqueue SB base = 0x2003 (tag 2), src = 0xAB → no `data_write` until `st_commit` with tag 2; then address 0x2000, mbe 1000, wdata 0xAB000000.
- **CDB wakeup:** enqueue LH with base invalid (tag 5); `cdb_valid[5]` with data 0x3002, imm = 0; rdata 0x8001xxxx → `ld_data` 0xFFFF8001. Repeat as LHU → 0x00008001.
- **Full and wrap:** enqueue DEPTH loads → `ldst_q_full` = 1 and a 5th enqueue is ignored; complete all in order; tags return in program order across the head/tail wrap.
- **Flush mid-request:** flush while in MEM with 3 entries → request held until resp, no `ld_done`, count = 0, `ldst_q_full` = 0.
- **Misalign (macro defined):** LW at 0x1002 → no `data_read`, `misalign` and `ld_done` pulse the same cycle, `ld_data` = 0.
